// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the fifo_ctrl controller slice.
// Holds the FSM state type and the pointer-width helper used by the top level and the arbiter.
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      FLUSH
   } ctrl_state_t;

   localparam int unsigned N_REQ_DEF   = 4;
   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned RST_CYC_DEF = 4;

   // Width of an index into n items; never narrower than one bit.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr, with wrap.
// The caller owns the pointer register.
module rr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned N  = N_REQ_DEF,
   parameter int unsigned PW = ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);

   logic          found;
   logic [PW-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = PW'((32'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      if (found) gnt[gnt_idx] = 1'b1;
   end

endmodule

// File: rtl/fifo_ctrl.sv
// Shares one standard-read FIFO between N_REQ round-robin producers and one consumer,
// hides the FIFO read latency with a 2-entry skid buffer and sequences the FIFO srst.
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ   = N_REQ_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned RST_CYC = RST_CYC_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    flush,
   output logic                    busy,
   output logic                    fifo_srst,
   output logic [DATA_W-1:0]       fifo_din,
   output logic                    fifo_wr_en,
   input  logic                    fifo_full,
   output logic                    fifo_rd_en,
   input  logic [DATA_W-1:0]       fifo_dout,
   input  logic                    fifo_empty,
   output logic                    m_valid,
   output logic [DATA_W-1:0]       m_data,
   input  logic                    m_ready
);

   localparam int unsigned   PW       = ptr_w(N_REQ);
   localparam int unsigned   CW       = ptr_w(RST_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYC - 1);

   ctrl_state_t       state;
   logic [CW-1:0]     cnt;
   logic [PW-1:0]     rr_ptr;
   logic [N_REQ-1:0]  gnt;
   logic [PW-1:0]     gnt_idx;
   logic              run;
   logic              grant;
   logic              pop;
   logic              inf;
   logic [1:0]        occ;
   logic [1:0]        load;
   logic [DATA_W-1:0] skid_h;
   logic [DATA_W-1:0] skid_t;

   rr_arbiter #(
      .N  (N_REQ),
      .PW (PW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // No handshake is offered in the cycle flush is seen, since the FIFO is about to be reset.
   assign run        = (state == RUN) && !flush;
   assign grant      = run && !fifo_full && (|req_valid);
   assign req_ready  = grant ? gnt : '0;
   assign fifo_wr_en = grant;

   always_comb begin
      fifo_din = '0;
      for (int unsigned i = 0; i < N_REQ; i++)
         if (req_ready[i]) fifo_din = req_data[i*DATA_W +: DATA_W];
   end

   assign m_valid    = (occ != 2'd0);
   assign m_data     = skid_h;
   assign pop        = m_valid && m_ready;
   // occ + inf never exceeds 2, so the post-pop load fits in two bits.
   assign load       = occ + {1'b0, inf} - {1'b0, pop};
   assign fifo_rd_en = run && !fifo_empty && (load < 2'd2);

   // busy is the registered copy of (state != RUN), so it trails the state by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         cnt       <= '0;
         fifo_srst <= 1'b1;
         busy      <= 1'b0;
      end else begin
         busy <= (state != RUN);
         case (state)
            INIT, FLUSH: begin
               if (cnt == CNT_LAST) begin
                  state     <= RUN;
                  fifo_srst <= 1'b0;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (flush) begin
                  state     <= FLUSH;
                  fifo_srst <= 1'b1;
                  cnt       <= '0;
               end
            end
            default: begin
               state     <= INIT;
               fifo_srst <= 1'b1;
               cnt       <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (grant) begin
         rr_ptr <= (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // The returning word lands at slot (occ - pop): the head when that is zero, else the tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ    <= '0;
         inf    <= 1'b0;
         skid_h <= '0;
         skid_t <= '0;
      end else if (state == RUN && flush) begin
         occ <= '0;
         inf <= 1'b0;
      end else begin
         occ <= load;
         inf <= fifo_rd_en;
         if (pop) skid_h <= skid_t;
         if (inf) begin
            if (occ == {1'b0, pop}) skid_h <= fifo_dout;
            else                    skid_t <= fifo_dout;
         end
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed and random bench for fifo_ctrl with a behavioural standard-read FIFO (depth 16,
// empty deasserting one cycle after a write).
module tb_fifo_ctrl;

   localparam int unsigned N     = 4;
   localparam int unsigned W     = 8;
   localparam int unsigned RC    = 4;
   localparam int unsigned DEPTH = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0] req_ready;
   logic         flush = 1'b0;
   logic         busy;
   logic         fifo_srst;
   logic [W-1:0] fifo_din;
   logic         fifo_wr_en;
   logic         fifo_full = 1'b0;
   logic         fifo_rd_en;
   logic [W-1:0] fifo_dout = '0;
   logic         fifo_empty = 1'b1;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         m_ready = 1'b0;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   logic [W-1:0] fq[$];
   logic [W-1:0] olog[$];
   int           ocyc[$];
   logic [W-1:0] sb[N][$];

   always #5 clk = ~clk;

   fifo_ctrl #(
      .N_REQ   (N),
      .DATA_W  (W),
      .RST_CYC (RC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .flush      (flush),
      .busy       (busy),
      .fifo_srst  (fifo_srst),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready)
   );

   // A word written at an edge only becomes visible to empty one edge later.
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (fifo_srst) begin
         fq.delete();
         fifo_empty <= 1'b1;
         fifo_full  <= 1'b0;
      end else begin
         if (fifo_rd_en && !fifo_empty) fifo_dout <= fq.pop_front();
         if (fifo_wr_en && !fifo_full) begin
            fq.push_back(fifo_din);
            fifo_empty <= (fq.size() == 1);
         end else begin
            fifo_empty <= (fq.size() == 0);
         end
         fifo_full <= (fq.size() >= DEPTH);
      end
   end

   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         olog.push_back(m_data);
         ocyc.push_back(cycle);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; m_ready = 1'b0; flush = 1'b0;
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (fifo_srst !== 1'b1) begin bad++; $display("FAIL rst_srst got %0b want 1", fifo_srst); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %0b want 0", busy); end
         total++; if ({req_ready, fifo_wr_en, fifo_rd_en, m_valid} !== 7'd0) begin bad++;
            $display("FAIL rst_hs got %0b want 0", {req_ready, fifo_wr_en, fifo_rd_en, m_valid}); end
      end
      rst = 1'b0; req_valid = 4'b0001; req_data = 32'h19; #1;
      for (int i = 1; i <= 4; i++) begin
         total++; if (fifo_srst !== 1'b1) begin bad++; $display("FAIL init_srst c%0d got %0b want 1", i, fifo_srst); end
         total++; if (busy !== (i != 1)) begin bad++; $display("FAIL init_busy c%0d got %0b want %0b", i, busy, i != 1); end
         total++; if ({req_ready, fifo_wr_en, fifo_rd_en, m_valid} !== 7'd0) begin bad++;
            $display("FAIL init_hs c%0d got %0b want 0", i, {req_ready, fifo_wr_en, fifo_rd_en, m_valid}); end
         tick();
      end
      total++; if (fifo_srst !== 1'b0) begin bad++; $display("FAIL run_srst got %0b want 0", fifo_srst); end
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL run_ready got %b want 0001", req_ready); end
      req_valid = '0;
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL run_busy got %0b want 0", busy); end
   endtask

   task automatic test_single();
      m_ready = 1'b0; req_data = '0; req_data[7:0] = 8'd25; req_valid = 4'b0001; #1;
      total++; if (req_ready !== 4'b0001 || fifo_wr_en !== 1'b1) begin bad++;
         $display("FAIL single_wr got ready=%b wr=%0b want 0001/1", req_ready, fifo_wr_en); end
      total++; if (fifo_din !== 8'd25) begin bad++; $display("FAIL single_din got %0d want 25", fifo_din); end
      tick();
      req_valid = '0;
      for (int k = 1; k <= 3; k++) begin
         total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_early c%0d got %0b want 0", k, m_valid); end
         total++; if (fifo_rd_en !== (k == 2)) begin bad++; $display("FAIL single_rd c%0d got %0b want %0b", k, fifo_rd_en, k == 2); end
         tick();
      end
      total++; if (m_valid !== 1'b1 || m_data !== 8'd25) begin bad++;
         $display("FAIL single_out got v=%0b d=%0d want 1/25", m_valid, m_data); end
      m_ready = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_dup c%0d got %0b want 0", k, m_valid); end
         tick();
      end
      m_ready = 1'b0;
   endtask

   task automatic test_rr();
      logic [N-1:0] exp_g;
      do_reset();
      olog.delete();
      req_data = {8'd40, 8'd30, 8'd20, 8'd10}; req_valid = '1; m_ready = 1'b1; #1;
      for (int k = 0; k < 12; k++) begin
         exp_g = 4'b0001 << (k % 4);
         total++; if (req_ready !== exp_g) begin bad++; $display("FAIL rr_gnt k%0d got %b want %b", k, req_ready, exp_g); end
         total++; if (fifo_din !== 8'(10 * (k % 4 + 1))) begin bad++;
            $display("FAIL rr_din k%0d got %0d want %0d", k, fifo_din, 10 * (k % 4 + 1)); end
         tick();
      end
      req_valid = '0;
      repeat (10) tick();
      total++; if (olog.size() != 12) begin bad++; $display("FAIL rr_count got %0d want 12", olog.size()); end
      for (int k = 0; k < 12 && k < olog.size(); k++) begin
         total++; if (olog[k] !== 8'(10 * (k % 4 + 1))) begin bad++;
            $display("FAIL rr_order k%0d got %0d want %0d", k, olog[k], 10 * (k % 4 + 1)); end
      end
   endtask

   task automatic test_full();
      int accepted = 0;
      int saw_full = 0;
      olog.delete(); ocyc.delete();
      m_ready = 1'b0;
      for (int k = 0; k < 30; k++) begin
         req_valid = 4'b0100; req_data = '0; req_data[2*W +: W] = 8'(100 + accepted); #1;
         if (fifo_full) begin
            saw_full = 1;
            total++; if (req_ready !== '0 || fifo_wr_en !== 1'b0) begin bad++;
               $display("FAIL full_gnt k%0d got ready=%b wr=%0b want 0000/0", k, req_ready, fifo_wr_en); end
         end
         if (req_ready[2]) accepted++;
         tick();
      end
      req_valid = '0;
      tick();
      total++; if (saw_full != 1) begin bad++; $display("FAIL full_seen got %0d want 1", saw_full); end
      total++; if (accepted != 18) begin bad++; $display("FAIL full_accepted got %0d want 18", accepted); end
      total++; if (m_valid !== 1'b1 || m_data !== 8'd100) begin bad++;
         $display("FAIL full_head got v=%0b d=%0d want 1/100", m_valid, m_data); end
      total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL full_skid_rd got %0b want 0", fifo_rd_en); end
      m_ready = 1'b1;
      repeat (25) tick();
      total++; if (olog.size() != 18) begin bad++; $display("FAIL drain_count got %0d want 18", olog.size()); end
      for (int k = 0; k < 18 && k < olog.size(); k++) begin
         total++; if (olog[k] !== 8'(100 + k) || ocyc[k] != ocyc[0] + k) begin bad++;
            $display("FAIL drain_k%0d got d=%0d cyc+%0d want d=%0d cyc+%0d", k, olog[k], ocyc[k] - ocyc[0], 100 + k, k); end
      end
      m_ready = 1'b0;
   endtask

   task automatic test_flush();
      olog.delete();
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         req_valid = 4'b0010; req_data = '0; req_data[W +: W] = 8'(k + 1);
         tick();
      end
      req_valid = '0;
      repeat (4) tick();
      total++; if (m_valid !== 1'b1 || m_data !== 8'd1) begin bad++;
         $display("FAIL flush_pre got v=%0b d=%0d want 1/1", m_valid, m_data); end
      flush = 1'b1;
      tick();
      flush = 1'b0; req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'd50; #1;
      for (int i = 1; i <= 4; i++) begin
         total++; if (fifo_srst !== 1'b1) begin bad++; $display("FAIL flush_srst f%0d got %0b want 1", i, fifo_srst); end
         total++; if (m_valid !== 1'b0 || req_ready !== '0) begin bad++;
            $display("FAIL flush_hs f%0d got v=%0b ready=%b want 0/0000", i, m_valid, req_ready); end
         if (i > 1) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy f%0d got %0b want 1", i, busy); end
         end
         tick();
      end
      total++; if (fifo_srst !== 1'b0 || req_ready !== 4'b0001 || fifo_din !== 8'd50) begin bad++;
         $display("FAIL flush_resume got srst=%0b ready=%b din=%0d want 0/0001/50", fifo_srst, req_ready, fifo_din); end
      tick();
      req_valid = '0; m_ready = 1'b1;
      repeat (8) tick();
      total++; if (olog.size() != 1) begin bad++; $display("FAIL flush_count got %0d want 1", olog.size()); end
      if (olog.size() > 0) begin
         total++; if (olog[0] !== 8'd50) begin bad++; $display("FAIL flush_first got %0d want 50", olog[0]); end
      end
      m_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [N-1:0] v;
      logic [N-1:0] exp_g;
      logic [W-1:0] d[N];
      int unsigned  tbptr;
      int unsigned  idx;
      int sent = 0, rcvd = 0, cycles = 0, id;
      logic [W-1:0] want;
      do_reset();
      v = '0; tbptr = 0;
      for (int i = 0; i < N; i++) begin d[i] = '0; sb[i].delete(); end
      while ((sent < 1000 || rcvd < sent) && cycles < 20000) begin
         for (int i = 0; i < N; i++) begin
            if (!v[i] && (sent + $countones(v)) < 1000 && $urandom_range(1, 0) != 0) begin
               v[i] = 1'b1;
               d[i] = {2'(i), 6'($urandom_range(63, 0))};
            end
            req_data[i*W +: W] = d[i];
         end
         req_valid = v;
         m_ready = 1'($urandom_range(1, 0));
         #1;
         exp_g = '0;
         if (!fifo_full) begin
            for (int unsigned k = 0; k < N; k++) begin
               idx = (tbptr + k) % N;
               if (v[idx] && exp_g == '0) exp_g[idx] = 1'b1;
            end
         end
         total++; if (req_ready !== exp_g) begin bad++;
            $display("FAIL rand_gnt cyc%0d got %b want %b", cycles, req_ready, exp_g); end
         for (int unsigned i = 0; i < N; i++) begin
            if (exp_g[i]) tbptr = (i + 1) % N;
            if (req_ready[i] && v[i]) begin
               total++; if (fifo_din !== d[i]) begin bad++;
                  $display("FAIL rand_din cyc%0d got %0h want %0h", cycles, fifo_din, d[i]); end
               sb[i].push_back(d[i]);
               v[i] = 1'b0;
               sent++;
            end
         end
         if (m_valid && m_ready) begin
            id = int'(m_data[7:6]);
            want = (sb[id].size() > 0) ? sb[id].pop_front() : ~m_data;
            total++; if (m_data !== want) begin bad++;
               $display("FAIL rand_out p%0d got %0h want %0h", id, m_data, want); end
            rcvd++;
         end
         tick();
         cycles++;
      end
      req_valid = '0; m_ready = 1'b0;
      total++; if (cycles >= 20000) begin bad++; $display("FAIL rand_timeout got %0d cycles want <20000", cycles); end
      total++; if (sent != 1000 || rcvd != 1000) begin bad++;
         $display("FAIL rand_count got sent=%0d rcvd=%0d want 1000/1000", sent, rcvd); end
      for (int i = 0; i < N; i++) begin
         total++; if (sb[i].size() != 0) begin bad++; $display("FAIL rand_left p%0d got %0d want 0", i, sb[i].size()); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr();
      test_full();
      test_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
